automat_comanda: RTL and testbench

- Vending-machine control FSM for the lemonade dispenser.
- Sits directly downstream of the per-button debouncers. Consumes their one-cycle, edge-detected press pulses: coin, select and cancel.
- Tracks inserted credit, runs a timed dispense cycle, returns change and flags user errors.
- All outputs are registered and drive the display and actuator logic.

---
 rtl/automat_comanda.sv | 155 +++++++++++++++
 tb/tb_automat_comanda.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/automat_comanda.sv
// Lemonade vending controller: credit tracking, timed dispense, change return.
// Optional stock tracking is enabled by defining AUTOMAT_STOC_EN.
//
// state      | meaning
// S_IDLE     | no credit held, waiting for coins
// S_CREDIT   | credit > 0, waiting for select/cancel/more coins
// S_DISPENSE | valve open, dispense timer running
// S_REST     | one cycle of change return (rest_valid high)
module automat_comanda #(
   parameter int PRET       = 3,
   parameter int CREDIT_MAX = 9,
   parameter int T_DISPENSE = 200000000,
   parameter int STOC_INIT  = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       p_ban,
   input  logic       p_select,
   input  logic       p_anulare,
   output logic [3:0] credit,
   output logic       dispensing,
   output logic [3:0] rest,
   output logic       rest_valid,
   output logic       ban_respins,
   output logic       err_fonduri,
   output logic       fara_stoc
);

   typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_REST} state_t;

   localparam logic [3:0]  PRET_L = 4'(PRET);
   localparam logic [3:0]  CMAX_L = 4'(CREDIT_MAX);
   localparam logic [27:0] T_LAST = 28'(T_DISPENSE - 1);

   state_t      state, state_nxt;
   logic [27:0] timer, timer_nxt;
   logic [3:0]  credit_nxt, rest_nxt;
   logic        disp_nxt, rv_nxt, ban_nxt, err_nxt;
   logic        stock_ok, buy;

   assign buy = (state == S_IDLE || state == S_CREDIT) && !p_anulare && p_select
                && stock_ok && (credit >= PRET_L);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         credit      <= '0;
         rest        <= '0;
         dispensing  <= 1'b0;
         rest_valid  <= 1'b0;
         ban_respins <= 1'b0;
         err_fonduri <= 1'b0;
      end else begin
         state       <= state_nxt;
         timer       <= timer_nxt;
         credit      <= credit_nxt;
         rest        <= rest_nxt;
         dispensing  <= disp_nxt;
         rest_valid  <= rv_nxt;
         ban_respins <= ban_nxt;
         err_fonduri <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_CREDIT: begin
            if (p_anulare) begin
               if (state == S_CREDIT) state_nxt = S_REST;
            end else if (p_select) begin
               if (buy) state_nxt = S_DISPENSE;
            end else if (p_ban && credit < CMAX_L) begin
               state_nxt = S_CREDIT;
            end
         end
         S_DISPENSE: if (timer == '0) state_nxt = (credit != '0) ? S_REST : S_IDLE;
         S_REST:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Timer counts down from T_DISPENSE-1; terminal count closes the valve.
   always_comb begin
      timer_nxt  = timer;
      credit_nxt = credit;
      rest_nxt   = rest;
      disp_nxt   = 1'b0;
      rv_nxt     = 1'b0;
      ban_nxt    = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         S_IDLE, S_CREDIT: begin
            if (p_anulare) begin
               if (state == S_CREDIT) begin
                  rest_nxt   = credit;
                  credit_nxt = '0;
                  rv_nxt     = 1'b1;
               end
            end else if (p_select) begin
               if (buy) begin
                  credit_nxt = credit - PRET_L;
                  timer_nxt  = T_LAST;
                  disp_nxt   = 1'b1;
               end else if (stock_ok) begin
                  err_nxt = 1'b1;
               end
            end else if (p_ban) begin
               if (credit < CMAX_L) credit_nxt = credit + 4'd1;
               else                 ban_nxt    = 1'b1;
            end
         end
         S_DISPENSE: begin
            ban_nxt = p_ban;
            if (timer == '0) begin
               if (credit != '0) begin
                  rest_nxt   = credit;
                  credit_nxt = '0;
                  rv_nxt     = 1'b1;
               end
            end else begin
               timer_nxt = timer - 28'd1;
               disp_nxt  = 1'b1;
            end
         end
         S_REST:  ban_nxt = p_ban;
         default: ;
      endcase
   end

`ifdef AUTOMAT_STOC_EN
   logic [3:0] stock, stock_nxt;

   assign stock_ok  = (stock != 4'd0);
   assign stock_nxt = buy ? stock - 4'd1 : stock;

   always_ff @(posedge clk) begin
      if (rst) begin
         stock     <= 4'(STOC_INIT);
         fara_stoc <= 1'b0;
      end else begin
         stock     <= stock_nxt;
         fara_stoc <= (stock_nxt == 4'd0);
      end
   end
`else
   logic unused_stoc;

   assign unused_stoc = ^STOC_INIT;
   assign stock_ok    = 1'b1;
   assign fara_stoc   = 1'b0;
`endif

endmodule

// File: tb/tb_automat_comanda.sv
// Bench for automat_comanda: directed vector table, reset/stock sequences,
// and random pulses checked against a cycle-count reference model.
module tb_automat_comanda;
   localparam int PRET  = 3;
   localparam int CMAX  = 9;
   localparam int TDISP = 10;
`ifdef AUTOMAT_STOC_EN
   localparam int STOC_INIT = 1;
   localparam bit STOC_EN   = 1'b1;
`else
   localparam int STOC_INIT = 5;
   localparam bit STOC_EN   = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0, p_ban = 1'b0, p_select = 1'b0, p_anulare = 1'b0;
   logic [3:0] credit, rest;
   logic       dispensing, rest_valid, ban_respins, err_fonduri, fara_stoc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   automat_comanda #(
      .PRET(PRET), .CREDIT_MAX(CMAX), .T_DISPENSE(TDISP), .STOC_INIT(STOC_INIT)
   ) dut (
      .clk(clk), .rst(rst), .p_ban(p_ban), .p_select(p_select), .p_anulare(p_anulare),
      .credit(credit), .dispensing(dispensing), .rest(rest), .rest_valid(rest_valid),
      .ban_respins(ban_respins), .err_fonduri(err_fonduri), .fara_stoc(fara_stoc)
   );

   // Reference model: busy = cycles of valve time still to come.
   int m_credit, m_busy, m_rest, m_stock;
   bit m_in_rest, e_rv, e_ban, e_err, e_fara;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_credit = 0; m_busy = 0; m_rest = 0; m_stock = STOC_INIT;
      m_in_rest = 0; e_rv = 0; e_ban = 0; e_err = 0; e_fara = 0;
   endtask

   task automatic model_update(input bit b, input bit s, input bit a);
      e_rv = 0; e_ban = 0; e_err = 0;
      if (m_in_rest) begin
         m_in_rest = 0;
         e_ban = b;
      end else if (m_busy > 0) begin
         e_ban = b;
         m_busy--;
         if (m_busy == 0 && m_credit > 0) begin
            m_rest = m_credit; m_credit = 0; e_rv = 1; m_in_rest = 1;
         end
      end else if (a) begin
         if (m_credit > 0) begin
            m_rest = m_credit; m_credit = 0; e_rv = 1; m_in_rest = 1;
         end
      end else if (s) begin
         if (STOC_EN && m_stock == 0) begin
            e_err = 0;
         end else if (m_credit >= PRET) begin
            m_credit -= PRET; m_busy = TDISP; m_stock--;
         end else begin
            e_err = 1;
         end
      end else if (b) begin
         if (m_credit < CMAX) m_credit++;
         else e_ban = 1;
      end
      e_fara = STOC_EN && (m_stock == 0);
   endtask

   task automatic check_model();
      chk("credit", credit, m_credit);
      chk("dispensing", dispensing, m_busy > 0);
      chk("rest", rest, m_rest);
      chk("rest_valid", rest_valid, e_rv);
      chk("ban_respins", ban_respins, e_ban);
      chk("err_fonduri", err_fonduri, e_err);
      chk("fara_stoc", fara_stoc, e_fara);
   endtask

   task automatic step(input bit b, input bit s, input bit a);
      @(negedge clk);
      rst = 1'b0; p_ban = b; p_select = s; p_anulare = a;
      @(posedge clk);
      #1;
      model_update(b, s, a);
      check_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; p_ban = 1'b0; p_select = 1'b0; p_anulare = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      check_model();
   endtask

   typedef struct {
      bit rs; bit b; bit s; bit a; int rep;
      int credit; bit disp; bit rv; int rest; bit banr; bit err;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t v(bit rs, bit b, bit s, bit a, int rep,
                              int c, bit d, bit rv, int r, bit br, bit er);
      vec_t x;
      x.rs = rs; x.b = b; x.s = s; x.a = a; x.rep = rep;
      x.credit = c; x.disp = d; x.rv = rv; x.rest = r; x.banr = br; x.err = er;
      return x;
   endfunction

   initial begin
      model_reset();
      // Exact-price buy, no change
      tbl.push_back(v(1,1,0,0,1, 1,0,0,0,0,0));
      tbl.push_back(v(0,1,0,0,1, 2,0,0,0,0,0));
      tbl.push_back(v(0,1,0,0,1, 3,0,0,0,0,0));
      tbl.push_back(v(0,0,1,0,1, 0,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,9, 0,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,2, 0,0,0,0,0,0));
      // Buy with change
      for (int k = 1; k <= 5; k++) tbl.push_back(v(k == 1,1,0,0,1, k,0,0,0,0,0));
      tbl.push_back(v(0,0,1,0,1, 2,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,9, 2,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,1, 0,0,1,2,0,0));
      tbl.push_back(v(0,0,0,0,1, 0,0,0,2,0,0));
      // Insufficient funds, then cancel
      tbl.push_back(v(1,1,0,0,1, 1,0,0,0,0,0));
      tbl.push_back(v(0,1,0,0,1, 2,0,0,0,0,0));
      tbl.push_back(v(0,0,1,0,1, 2,0,0,0,0,1));
      tbl.push_back(v(0,0,0,0,1, 2,0,0,0,0,0));
      tbl.push_back(v(0,0,0,1,1, 0,0,1,2,0,0));
      tbl.push_back(v(0,0,0,0,1, 0,0,0,2,0,0));
      // Saturation and coin during dispense
      for (int k = 1; k <= 9; k++) tbl.push_back(v(k == 1,1,0,0,1, k,0,0,0,0,0));
      tbl.push_back(v(0,1,0,0,1, 9,0,0,0,1,0));
      tbl.push_back(v(0,0,0,0,1, 9,0,0,0,0,0));
      tbl.push_back(v(0,0,1,0,1, 6,1,0,0,0,0));
      tbl.push_back(v(0,1,0,0,1, 6,1,0,0,1,0));
      tbl.push_back(v(0,0,0,0,8, 6,1,0,0,0,0));
      tbl.push_back(v(0,0,0,0,1, 0,0,1,6,0,0));
      tbl.push_back(v(0,0,0,0,1, 0,0,0,6,0,0));
      // Cancel beats select; priority in IDLE
      for (int k = 1; k <= 4; k++) tbl.push_back(v(k == 1,1,0,0,1, k,0,0,0,0,0));
      tbl.push_back(v(0,0,1,1,1, 0,0,1,4,0,0));
      tbl.push_back(v(0,0,0,0,1, 0,0,0,4,0,0));
      tbl.push_back(v(0,1,1,1,1, 0,0,0,4,0,0));
      tbl.push_back(v(0,1,1,0,1, 0,0,0,4,0,1));

      foreach (tbl[i]) begin
         if (tbl[i].rs) do_reset();
         for (int r = 0; r < tbl[i].rep; r++) step(tbl[i].b, tbl[i].s, tbl[i].a);
         chk($sformatf("v%0d credit", i), credit, tbl[i].credit);
         chk($sformatf("v%0d dispensing", i), dispensing, tbl[i].disp);
         chk($sformatf("v%0d rest_valid", i), rest_valid, tbl[i].rv);
         chk($sformatf("v%0d rest", i), rest, tbl[i].rest);
         chk($sformatf("v%0d ban_respins", i), ban_respins, tbl[i].banr);
         chk($sformatf("v%0d err_fonduri", i), err_fonduri, tbl[i].err);
      end

      // Reset in the middle of a dispense drops valve and credit
      do_reset();
      for (int k = 0; k < 5; k++) step(1, 0, 0);
      step(0, 1, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 0);
      chk("mid_disp pre dispensing", dispensing, 1);
      chk("mid_disp pre credit", credit, 2);
      do_reset();
      chk("mid_disp rst dispensing", dispensing, 0);
      chk("mid_disp rst credit", credit, 0);
      for (int k = 0; k < 12; k++) begin
         step(0, 0, 0);
         chk("mid_disp no rest_valid", rest_valid, 0);
      end

`ifdef AUTOMAT_STOC_EN
      do_reset();
      for (int k = 0; k < 3; k++) step(1, 0, 0);
      step(0, 1, 0);
      chk("stoc fara after buy", fara_stoc, 1);
      for (int k = 0; k < TDISP; k++) step(0, 0, 0);
      for (int k = 0; k < 3; k++) step(1, 0, 0);
      chk("stoc coins accepted", credit, 3);
      step(0, 1, 0);
      chk("stoc no dispense", dispensing, 0);
      chk("stoc no err", err_fonduri, 0);
      chk("stoc credit kept", credit, 3);
      step(0, 0, 1);
      chk("stoc refund valid", rest_valid, 1);
      chk("stoc refund rest", rest, 3);
`endif

      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 9) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
